// File: rtl/orv64_typedef_pkg.sv
// Shared types and constants for the ORV64 AMO sequencer.
package orv64_typedef_pkg;

   typedef enum logic [3:0] {
      AMO_SWAP = 4'd0,
      AMO_ADD  = 4'd1,
      AMO_XOR  = 4'd2,
      AMO_AND  = 4'd3,
      AMO_OR   = 4'd4,
      AMO_MIN  = 4'd5,
      AMO_MAX  = 4'd6,
      AMO_MINU = 4'd7,
      AMO_MAXU = 4'd8
   } orv64_amo_op_t;

   typedef enum logic [2:0] {
      AMO_IDLE    = 3'd0,
      AMO_LD_REQ  = 3'd1,
      AMO_LD_WAIT = 3'd2,
      AMO_ST_REQ  = 3'd3,
      AMO_ST_WAIT = 3'd4,
      AMO_DONE    = 3'd5
   } orv64_amo_state_t;

   localparam logic [7:0] ORV64_AMO_MASK_W_LO = 8'h0F;
   localparam logic [7:0] ORV64_AMO_MASK_W_HI = ~ORV64_AMO_MASK_W_LO;
   localparam logic [7:0] ORV64_AMO_MASK_D    = 8'hFF;

   function automatic logic amo_misaligned(input logic is_word, input logic [2:0] addr_lo);
      return is_word ? (addr_lo[1:0] != 2'b00) : (addr_lo != 3'b000);
   endfunction

   function automatic logic [7:0] amo_mask(input logic is_word, input logic addr_b2);
      if (!is_word)
         return ORV64_AMO_MASK_D;
      return addr_b2 ? ORV64_AMO_MASK_W_HI : ORV64_AMO_MASK_W_LO;
   endfunction

endpackage

// File: rtl/orv64_amo_alu.sv
// Combinational AMO result: new memory value from the old value and rs2.
import orv64_typedef_pkg::*;

module orv64_amo_alu #(
   parameter int XLEN = 64
) (
   input  orv64_amo_op_t           op,
   input  logic                    is_word,
   input  logic signed [XLEN-1:0]  old_val,
   input  logic signed [XLEN-1:0]  rs2_val,
   output logic signed [XLEN-1:0]  result
);

   logic signed [XLEN-1:0] a, b, r;
   logic        [XLEN-1:0] ua, ub;
   logic                   lt_s, lt_u;

   // .W operands are sign-extended for the signed compare and zero-extended for
   // the unsigned one, so a single 64-bit comparator serves both widths.
   always_comb begin
      a  = old_val;
      b  = rs2_val;
      ua = old_val;
      ub = rs2_val;
      if (is_word) begin
         a  = {{(XLEN-32){old_val[31]}}, old_val[31:0]};
         b  = {{(XLEN-32){rs2_val[31]}}, rs2_val[31:0]};
         ua = {{(XLEN-32){1'b0}}, old_val[31:0]};
         ub = {{(XLEN-32){1'b0}}, rs2_val[31:0]};
      end
      lt_s = a < b;
      lt_u = ua < ub;
      case (op)
         AMO_SWAP: r = b;
         AMO_ADD:  r = a + b;
         AMO_XOR:  r = a ^ b;
         AMO_AND:  r = a & b;
         AMO_OR:   r = a | b;
         AMO_MIN:  r = lt_s ? a : b;
         AMO_MAX:  r = lt_s ? b : a;
         AMO_MINU: r = lt_u ? a : b;
         AMO_MAXU: r = lt_u ? b : a;
         default:  r = a;
      endcase
      result = is_word ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
   end

endmodule

// File: rtl/orv64_amo_seq.sv
// EX-stage AMO sequencer: splits an AMO into a D-cache load and store and
// hands the old memory value to MA once the store completes.
import orv64_typedef_pkg::*;

module orv64_amo_seq #(
   parameter int XLEN    = 64,
   parameter int VADDR_W = 39
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  orv64_amo_op_t       amo_op,
   input  logic                is_word,
   input  logic                aq_rl,
   input  logic [VADDR_W-1:0]  addr,
   input  logic [XLEN-1:0]     rs2_data,
   input  logic                kill,
   output logic                req_valid,
   input  logic                req_ready,
   output logic                req_re,
   output logic                req_we,
   output logic                req_amo_load,
   output logic                req_amo_store,
   output logic                req_aq_rl,
   output logic [VADDR_W-1:0]  req_addr,
   output logic [XLEN-1:0]     req_wdata,
   output logic [7:0]          req_mask,
   input  logic                ld_valid,
   input  logic [XLEN-1:0]     ld_data,
   input  logic                ld_excp,
   input  logic                st_ack,
   input  logic                st_excp,
   input  logic                done_ack,
   output logic                busy,
   output logic                amo_done,
   output logic [XLEN-1:0]     rd_data,
   output logic                excp_valid,
   output logic                excp_misaligned
);

   orv64_amo_state_t        state;
   orv64_amo_op_t           op_p0;
   logic                    is_word_p0, aq_rl_p0, excp_p0, mis_p0, kill_pend;
   logic [VADDR_W-1:0]      addr_p0;
   logic signed [XLEN-1:0]  rs2_p0, old_p0, res_p0;
   logic signed [XLEN-1:0]  ld_old, alu_res;
   logic                    misaligned;

   assign misaligned = amo_misaligned(is_word, addr[2:0]);
   assign ld_old     = is_word_p0 ? {{(XLEN-32){ld_data[31]}}, ld_data[31:0]} : ld_data;

   orv64_amo_alu #(.XLEN(XLEN)) u_alu (
      .op      (op_p0),
      .is_word (is_word_p0),
      .old_val (ld_old),
      .rs2_val (rs2_p0),
      .result  (alu_res)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= AMO_IDLE;
         op_p0      <= AMO_SWAP;
         is_word_p0 <= 1'b0;
         aq_rl_p0   <= 1'b0;
         addr_p0    <= '0;
         rs2_p0     <= '0;
         old_p0     <= '0;
         res_p0     <= '0;
         excp_p0    <= 1'b0;
         mis_p0     <= 1'b0;
         kill_pend  <= 1'b0;
      end else begin
         case (state)
            AMO_IDLE: begin
               kill_pend <= 1'b0;
               if (start && !kill) begin
                  op_p0      <= amo_op;
                  is_word_p0 <= is_word;
                  aq_rl_p0   <= aq_rl;
                  addr_p0    <= addr;
                  rs2_p0     <= rs2_data;
                  old_p0     <= '0;
                  res_p0     <= '0;
                  excp_p0    <= misaligned;
                  mis_p0     <= misaligned;
                  state      <= misaligned ? AMO_DONE : AMO_LD_REQ;
               end
            end
            // Kill wins over a same-cycle accept: the request counts as never sent.
            AMO_LD_REQ: begin
               if (kill)           state <= AMO_IDLE;
               else if (req_ready) state <= AMO_LD_WAIT;
            end
            AMO_LD_WAIT: begin
               if (ld_valid) begin
                  if (kill_pend || kill) begin
                     state <= AMO_IDLE;
                  end else if (ld_excp) begin
                     excp_p0 <= 1'b1;
                     state   <= AMO_DONE;
                  end else begin
                     old_p0 <= ld_old;
                     res_p0 <= alu_res;
                     state  <= AMO_ST_REQ;
                  end
               end else if (kill) begin
                  kill_pend <= 1'b1;
               end
            end
            AMO_ST_REQ: begin
               if (kill)           state <= AMO_IDLE;
               else if (req_ready) state <= AMO_ST_WAIT;
            end
            AMO_ST_WAIT: begin
               if (st_ack) begin
                  if (kill_pend || kill) begin
                     state <= AMO_IDLE;
                  end else begin
                     excp_p0 <= st_excp;
                     state   <= AMO_DONE;
                  end
               end else if (kill) begin
                  kill_pend <= 1'b1;
               end
            end
            AMO_DONE: begin
               if (kill || done_ack) state <= AMO_IDLE;
            end
            default: state <= AMO_IDLE;
         endcase
      end
   end

   // All outputs decode registered state only.
   assign req_re        = (state == AMO_LD_REQ);
   assign req_we        = (state == AMO_ST_REQ);
   assign req_valid     = req_re | req_we;
   assign req_amo_load  = req_re;
   assign req_amo_store = req_we;
   assign req_aq_rl     = aq_rl_p0;
   assign req_addr      = addr_p0;
   assign req_wdata     = is_word_p0 ? {res_p0[31:0], res_p0[31:0]} : res_p0;
   assign req_mask      = req_valid ? amo_mask(is_word_p0, addr_p0[2]) : 8'h00;
   assign busy          = (state != AMO_IDLE);
   assign amo_done      = (state == AMO_DONE);
   assign rd_data       = old_p0;
   assign excp_valid    = amo_done & excp_p0;
   assign excp_misaligned = amo_done & mis_p0;

endmodule

// File: tb/tb_orv64_amo_seq.sv
// Directed bench for orv64_amo_seq with a reactive cache model and a scoreboard.
module tb_orv64_amo_seq;
   import orv64_typedef_pkg::*;

   localparam int XLEN = 64;
   localparam int VADDR_W = 39;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, is_word = 1'b0, aq_rl = 1'b0, kill = 1'b0;
   orv64_amo_op_t amo_op = AMO_SWAP;
   logic [VADDR_W-1:0] addr = '0;
   logic [XLEN-1:0] rs2_data = '0, ld_data = '0;
   logic req_ready = 1'b0, ld_valid = 1'b0, ld_excp = 1'b0, st_ack = 1'b0, st_excp = 1'b0, done_ack = 1'b0;
   logic req_valid, req_re, req_we, req_amo_load, req_amo_store, req_aq_rl;
   logic [VADDR_W-1:0] req_addr;
   logic [XLEN-1:0] req_wdata, rd_data;
   logic [7:0] req_mask;
   logic busy, amo_done, excp_valid, excp_misaligned;

   orv64_amo_seq #(.XLEN(XLEN), .VADDR_W(VADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .amo_op(amo_op), .is_word(is_word), .aq_rl(aq_rl),
      .addr(addr), .rs2_data(rs2_data), .kill(kill), .req_valid(req_valid), .req_ready(req_ready),
      .req_re(req_re), .req_we(req_we), .req_amo_load(req_amo_load), .req_amo_store(req_amo_store),
      .req_aq_rl(req_aq_rl), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_excp(ld_excp), .st_ack(st_ack), .st_excp(st_excp),
      .done_ack(done_ack), .busy(busy), .amo_done(amo_done), .rd_data(rd_data),
      .excp_valid(excp_valid), .excp_misaligned(excp_misaligned)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // cache knobs (main process) and expected behaviour (main process)
   bit ready_en = 1'b1, st_block = 1'b0, ld_excp_k = 1'b0, st_excp_k = 1'b0;
   int ld_delay = 0, st_delay = 0;
   logic [63:0] mem_val = '0;
   logic [VADDR_W-1:0] m_addr = '0;
   logic m_aqrl = 1'b0, m_ld_ok = 1'b0, m_st_ok = 1'b0, m_done_ok = 1'b0, m_excp = 1'b0, m_mis = 1'b0;
   logic [63:0] m_old = '0, m_wdata = '0;
   logic [7:0] m_mask = '0;

   // observations (scoreboard process)
   int n_ld = 0, n_st = 0, n_done = 0, ld_cyc = -1, st_cyc = -1, done_cyc = -1;
   logic [63:0] last_wdata = '0, last_rd = '0;
   logic [7:0] last_mask = '0;
   logic last_excp = 1'b0, last_mis = 1'b0, prev_done = 1'b0;
   bit ld_seen = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_amo(input orv64_amo_op_t op, input bit w,
                                             input logic [63:0] old, input logic [63:0] r2);
      longint signed sa, sb;
      longint unsigned ua, ub;
      logic [63:0] r;
      if (w) begin
         sa = longint'($signed(old[31:0]));  sb = longint'($signed(r2[31:0]));
         ua = {32'h0, old[31:0]};             ub = {32'h0, r2[31:0]};
      end else begin
         sa = $signed(old); sb = $signed(r2); ua = old; ub = r2;
      end
      case (op)
         AMO_SWAP: r = r2;
         AMO_ADD:  r = old + r2;
         AMO_XOR:  r = old ^ r2;
         AMO_AND:  r = old & r2;
         AMO_OR:   r = old | r2;
         AMO_MIN:  r = (sa < sb) ? old : r2;
         AMO_MAX:  r = (sa > sb) ? old : r2;
         AMO_MINU: r = (ua < ub) ? old : r2;
         default:  r = (ua > ub) ? old : r2;
      endcase
      return r;
   endfunction

   task automatic set_model(input orv64_amo_op_t op, input bit w, input logic [VADDR_W-1:0] a,
                            input logic [63:0] mem, input logic [63:0] r2, input bit aqrl);
      logic [63:0] r;
      r = model_amo(op, w, mem, r2);
      mem_val   = mem;
      m_addr    = a;
      m_aqrl    = aqrl;
      m_mis     = w ? (a[1:0] != 2'b00) : (a[2:0] != 3'b000);
      m_ld_ok   = !m_mis;
      m_st_ok   = !m_mis && !ld_excp_k;
      m_done_ok = 1'b1;
      m_excp    = m_mis || ld_excp_k || st_excp_k;
      m_old     = w ? {{32{mem[31]}}, mem[31:0]} : mem;
      m_wdata   = w ? {r[31:0], r[31:0]} : r;
      m_mask    = w ? (a[2] ? 8'hF0 : 8'h0F) : 8'hFF;
   endtask

   // D-cache responder: accepts when ready, answers delay+1 cycles after accept
   initial begin
      int ld_cnt, st_cnt;
      ld_cnt = -1; st_cnt = -1;
      forever begin
         @(negedge clk); #1;
         ld_valid = 1'b0; ld_excp = 1'b0; st_ack = 1'b0; st_excp = 1'b0;
         if (ld_cnt == 0) begin ld_valid = 1'b1; ld_data = mem_val; ld_excp = ld_excp_k; end
         if (ld_cnt >= 0) ld_cnt--;
         if (st_cnt == 0) begin st_ack = 1'b1; st_excp = st_excp_k; end
         if (st_cnt >= 0) st_cnt--;
         req_ready = ready_en && !(st_block && req_we);
         if (rst && req_valid && req_ready && !kill) begin
            if (req_re) ld_cnt = ld_delay;
            if (req_we) st_cnt = st_delay;
         end
      end
   end

   // Scoreboard: every request and every done cycle is checked against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            if (!busy) ld_seen = 1'b0;
            else if (ld_valid) ld_seen = 1'b1;
            if (req_valid) begin
               chk("req_allowed", 64'(ld_seen ? m_st_ok : m_ld_ok), 64'd1);
               chk("req_kind", 64'({req_re, req_we, req_amo_load, req_amo_store}), 64'(ld_seen ? 4'b0101 : 4'b1010));
               chk("req_addr", 64'(req_addr), 64'(m_addr));
               chk("req_aq_rl", 64'(req_aq_rl), 64'(m_aqrl));
               chk("req_mask", 64'(req_mask), 64'(m_mask));
               if (req_re) begin n_ld++; ld_cyc = cyc; end
               if (req_we) begin
                  chk("req_wdata", req_wdata, m_wdata);
                  n_st++; st_cyc = cyc; last_wdata = req_wdata; last_mask = req_mask;
               end
            end
            if (amo_done) begin
               chk("done_allowed", 64'(m_done_ok), 64'd1);
               chk("excp_valid", 64'(excp_valid), 64'(m_excp));
               chk("excp_misaligned", 64'(excp_misaligned), 64'(m_mis));
               if (!m_excp) chk("rd_data", rd_data, m_old);
               if (!prev_done) begin n_done++; done_cyc = cyc; end
               last_rd = rd_data; last_excp = excp_valid; last_mis = excp_misaligned;
            end
            prev_done = amo_done;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

   task automatic issue(input orv64_amo_op_t op, input bit w, input logic [VADDR_W-1:0] a,
                        input logic [63:0] r2, input bit aqrl, output int t0);
      @(negedge clk);
      t0 = cyc;
      start = 1'b1; amo_op = op; is_word = w; addr = a; rs2_data = r2; aq_rl = aqrl;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_req(input bit want_we, input string nm);
      int n;
      n = 0;
      while (!(req_valid === 1'b1 && req_we === want_we) && n < 30) begin @(negedge clk); n++; end
      if (n >= 30) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_request required=request", nm);
      end
   endtask

   task automatic run_amo(input orv64_amo_op_t op, input bit w, input logic [VADDR_W-1:0] a,
                          input logic [63:0] mem, input logic [63:0] r2, input bit aqrl, output int t0);
      int n;
      set_model(op, w, a, mem, r2, aqrl);
      issue(op, w, a, r2, aqrl, t0);
      n = 0;
      while (amo_done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (amo_done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=amo_done_low required=amo_done_high");
      end else begin
         done_ack = 1'b1;
         @(negedge clk);
         done_ack = 1'b0;
         chk("busy_after_ack", 64'(busy), 64'd0);
      end
   endtask

   orv64_amo_op_t      t_op  [10] = '{AMO_XOR, AMO_AND, AMO_OR, AMO_MIN, AMO_MAXU,
                                      AMO_SWAP, AMO_ADD, AMO_MINU, AMO_MAX, AMO_MIN};
   bit                 t_w   [10] = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 1};
   logic [VADDR_W-1:0] t_a   [10] = '{39'h3000, 39'h3004, 39'h3008, 39'h3010, 39'h3014,
                                      39'h3018, 39'h301C, 39'h3020, 39'h3028, 39'h302C};
   logic [63:0]        t_mem [10] = '{64'hF0F0_0000_1234_5678, 64'h0000_0000_8000_00FF, 64'h1,
                                      64'h8000_0000_0000_0000, 64'h0000_0000_7FFF_FFFF,
                                      64'h0000_0000_DEAD_BEEF, 64'h0000_0000_FFFF_FFFF,
                                      64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h2};
   logic [63:0]        t_rs2 [10] = '{64'h0FF0_0000_FFFF_0000, 64'hFFFF_FFFF_F000_000F,
                                      64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000,
                                      64'h1234_5678_9ABC_DEF0, 64'h2, 64'h5,
                                      64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_FFFF_FFFE};

   initial begin
      int t0, s_ld, s_st, s_done, n;
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_amo_done", 64'(amo_done), 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      chk("rst_excp", 64'({excp_valid, excp_misaligned}), 64'd0);
      chk("rst_req_mask", 64'(req_mask), 64'd0);
      chk("rst_req_wdata", req_wdata, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // AMOADD.D, zero-wait cache, latency pinned
      run_amo(AMO_ADD, 1'b0, 39'h1000, 64'h5, 64'h3, 1'b1, t0);
      chk("add_d_ld_cycle", 64'(ld_cyc - t0), 64'd1);
      chk("add_d_st_cycle", 64'(st_cyc - t0), 64'd3);
      chk("add_d_done_cycle", 64'(done_cyc - t0), 64'd5);
      chk("add_d_wdata", last_wdata, 64'h8);
      chk("add_d_mask", 64'(last_mask), 64'hFF);
      chk("add_d_rd", last_rd, 64'h5);

      run_amo(AMO_MAX, 1'b1, 39'h1004, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, t0);
      chk("max_w_wdata", last_wdata, 64'h0000_0001_0000_0001);
      chk("max_w_mask", 64'(last_mask), 64'hF0);
      chk("max_w_rd", last_rd, 64'hFFFF_FFFF_FFFF_FFFF);

      run_amo(AMO_MINU, 1'b1, 39'h2000, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, t0);
      chk("minu_w_wdata", last_wdata, 64'h0000_0001_0000_0001);
      chk("minu_w_mask", 64'(last_mask), 64'h0F);
      chk("minu_w_rd", last_rd, 64'hFFFF_FFFF_FFFF_FFFF);

      for (int i = 0; i < 10; i++) begin
         run_amo(t_op[i], t_w[i], t_a[i], t_mem[i], t_rs2[i], 1'(i), t0);
         chk("tbl_done_cycle", 64'(done_cyc - t0), 64'd5);
      end

      // misaligned: no request, fault at T+1
      s_ld = n_ld;
      run_amo(AMO_SWAP, 1'b0, 39'h1003, 64'h0, 64'h7, 1'b0, t0);
      chk("mis_d_done_cycle", 64'(done_cyc - t0), 64'd1);
      chk("mis_d_no_req", 64'(n_ld - s_ld), 64'd0);
      chk("mis_d_flags", 64'({last_excp, last_mis}), 64'b11);
      run_amo(AMO_ADD, 1'b1, 39'h1006, 64'h0, 64'h7, 1'b0, t0);
      chk("mis_w_flags", 64'({last_excp, last_mis}), 64'b11);
      run_amo(AMO_ADD, 1'b1, 39'h1008, 64'h4, 64'h7, 1'b0, t0);
      chk("aligned_w_no_excp", 64'(last_excp), 64'd0);

      // load fault: no store, done with excp
      ld_excp_k = 1'b1; s_st = n_st;
      run_amo(AMO_ADD, 1'b1, 39'h4000, 64'h9, 64'h1, 1'b0, t0);
      ld_excp_k = 1'b0;
      chk("ld_excp_no_store", 64'(n_st - s_st), 64'd0);
      chk("ld_excp_flags", 64'({last_excp, last_mis}), 64'b10);

      st_excp_k = 1'b1;
      run_amo(AMO_OR, 1'b0, 39'h4008, 64'h9, 64'h6, 1'b0, t0);
      st_excp_k = 1'b0;
      chk("st_excp_flag", 64'(last_excp), 64'd1);

      // kill in IDLE blocks start
      set_model(AMO_ADD, 1'b0, 39'h4800, 64'h1, 64'h1, 1'b0);
      m_ld_ok = 1'b0; m_done_ok = 1'b0;
      @(negedge clk);
      start = 1'b1; kill = 1'b1; amo_op = AMO_ADD; is_word = 1'b0; addr = 39'h4800;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("kill_idle_busy", 64'(busy), 64'd0);

      // kill in ST_REQ with the cache stalling the store
      st_block = 1'b1; s_done = n_done;
      set_model(AMO_OR, 1'b0, 39'h5000, 64'h3, 64'h4, 1'b0);
      m_done_ok = 1'b0;
      issue(AMO_OR, 1'b0, 39'h5000, 64'h4, 1'b0, t0);
      wait_req(1'b1, "kill_st_req");
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_st_req_valid", 64'(req_valid), 64'd0);
      chk("kill_st_busy", 64'(busy), 64'd0);
      repeat (8) @(negedge clk);
      chk("kill_st_no_done", 64'(n_done - s_done), 64'd0);
      st_block = 1'b0;

      // kill in LD_WAIT, response 3 cycles later
      ld_delay = 3; s_st = n_st; s_done = n_done;
      set_model(AMO_ADD, 1'b0, 39'h6000, 64'h5, 64'h3, 1'b0);
      m_done_ok = 1'b0; m_st_ok = 1'b0;
      issue(AMO_ADD, 1'b0, 39'h6000, 64'h3, 1'b0, t0);
      wait_req(1'b0, "kill_ld_wait");
      @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_ld_wait_busy", 64'(busy), 64'd1);
      n = 0;
      while (ld_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("kill_ld_busy_after_resp", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      chk("kill_ld_no_store", 64'(n_st - s_st), 64'd0);
      chk("kill_ld_no_done", 64'(n_done - s_done), 64'd0);
      ld_delay = 0;

      // asynchronous reset in ST_WAIT; the late st_ack must be ignored
      st_delay = 3; s_done = n_done;
      set_model(AMO_XOR, 1'b0, 39'h7000, 64'hAA, 64'h55, 1'b0);
      m_done_ok = 1'b0;
      issue(AMO_XOR, 1'b0, 39'h7000, 64'h55, 1'b0, t0);
      wait_req(1'b1, "rst_st_wait");
      @(negedge clk);
      chk("st_wait_busy", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_rd", rd_data, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_late_ack_busy", 64'(busy), 64'd0);
      chk("rst_late_ack_no_done", 64'(n_done - s_done), 64'd0);
      st_delay = 0;

      run_amo(AMO_AND, 1'b0, 39'h7008, 64'hFF00, 64'h0FF0, 1'b1, t0);
      chk("recover_wdata", last_wdata, 64'h0F00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/orv64_amo_seq.md
Name: orv64_amo_seq

Overview:
- Atomic-memory-operation sequencer in the EX stage, directly upstream of the memory-access stage.
- Breaks each AMO into a D-cache load request (amo_load) and a store request (amo_store).
- Collects the load data that MA returns as ma2ex_amo_ld_data and computes the AMO result.
- Drives the is_amo_done qualifier that MA uses to retire the instruction.

Parameters:
- XLEN, 64, data width.
- VADDR_W, 39, virtual address width (ORV64_VIR_ADDR_WIDTH).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset; block is in reset while 0.
- start  in  1  valid, non-killed AMO in EX; sampled only in IDLE.
- amo_op  in  4  orv64_amo_op_t: SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU.
- is_word  in  1  1 = .W, 0 = .D.
- aq_rl  in  1  aq|rl of the instruction.
- addr  in  VADDR_W  effective address.
- rs2_data  in  XLEN  operand.
- kill  in  1  pipeline flush.
- req_valid  out  1  D-cache request valid.
- req_ready  in  1  D-cache accepts the request.
- req_re, req_we  out  1  read / write request.
- req_amo_load, req_amo_store  out  1  AMO phase tags.
- req_aq_rl  out  1  ordering flag.
- req_addr  out  VADDR_W  request address.
- req_wdata  out  XLEN  store data.
- req_mask  out  8  byte enables.
- ld_valid  in  1  load response (MA: dc2ma.valid & is_amo_load).
- ld_data  in  XLEN  ma2ex_amo_ld_data; already sign-extended for .W.
- ld_excp  in  1  load response carries a fault.
- st_ack  in  1  store response.
- st_excp  in  1  store response carries a fault.
- done_ack  in  1  MA retires the AMO (ma_valid & wb_ready).
- busy  out  1  state != IDLE.
- amo_done  out  1  result ready for MA.
- rd_data  out  XLEN  old memory value for rd.
- excp_valid  out  1  AMO faulted.
- excp_misaligned  out  1  fault is AMO address misaligned.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs and internal registers cleared to 0.
- FSM states: IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT, DONE. All outputs are decoded from registered state and registered operands; no input-to-output combinational path.
- IDLE:
  - start=1 latches op, addr, rs2_data, is_word and aq_rl.
  - Misaligned address (.W: addr[1:0]!=0; .D: addr[2:0]!=0): go to DONE with excp_valid=1, excp_misaligned=1. No request is issued.
  - Otherwise go to LD_REQ.
- LD_REQ:
  - Drives req_valid=1, req_re=1, req_amo_load=1.
  - req_ready=1 moves to LD_WAIT. req_valid is held stable until accepted.
- LD_WAIT:
  - ld_valid=1 latches the old value: .W uses ld_data[31:0] sign-extended; .D uses ld_data as is.
  - Computes the result and moves to ST_REQ.
  - ld_excp=1 moves to DONE with excp_valid=1 and no store.
- Arithmetic:
  - .W operates on the low 32 bits. MIN/MAX use a signed 32-bit compare; MINU/MAXU use an unsigned compare.
  - ADD wraps modulo 2^32 (.W) or 2^64 (.D).
  - .W store: req_wdata={res32,res32}, req_mask = addr[2] ? 8'hF0 : 8'h0F.
  - .D store: req_mask=8'hFF.
- ST_REQ: drives req_valid=1, req_we=1, req_amo_store=1, then moves to ST_WAIT on req_ready.
- ST_WAIT: st_ack moves to DONE; excp_valid=st_excp.
- DONE:
  - amo_done=1 and rd_data=old value, held until done_ack.
  - done_ack returns to IDLE the next cycle, so a new start is accepted one cycle later.
- Kill handling:
  - kill in LD_REQ or ST_REQ goes to IDLE immediately, even when req_ready is high the same cycle; kill has priority and the request is treated as not sent.
  - kill in LD_WAIT or ST_WAIT sets kill_pending. The block waits for the outstanding response, then goes to IDLE with no store and no amo_done.
  - kill in DONE goes to IDLE without waiting for done_ack.
  - kill in IDLE blocks start that cycle.
- req_aq_rl = latched aq_rl, applied to both phases.
- Minimum latency with zero-wait cache (start at T): LD handshake T+1, ld_valid T+2, ST handshake T+3, st_ack T+4, amo_done T+5.
- Reset mid-operation aborts immediately; outstanding responses arriving afterwards are ignored in IDLE.

Decomposition:
- orv64_typedef_pkg gets:
  - orv64_amo_op_t enum.
  - orv64_amo_state_t enum.
  - Constant ORV64_AMO_MASK_W_LO=8'h0F and its high-half complement.
- Sub-module orv64_amo_alu (combinational): op, is_word, old value and rs2 in; result out.
- Top module holds the FSM, operand registers and request drive.

Test Plan:
- AMOADD.D at addr 0x1000, mem=0x5, rs2=0x3, zero-wait cache:
  - Load request at T+1; store wdata=0x8, mask=0xFF.
  - amo_done at T+5 with rd_data=0x5.
- AMOMAX.W at addr 0x1004, ld_data[31:0]=0xFFFFFFFF, rs2=0x1:
  - Store wdata=0x0000000100000001, mask=0xF0.
  - rd_data=0xFFFFFFFFFFFFFFFF.
- AMOMINU.W at addr 0x2000 with the same values: result=0x1, mask=0x0F.
- AMOSWAP.D at addr 0x1003: no request issued; excp_valid=1 and excp_misaligned=1 at T+1.
- ld_excp=1 on the load response: no store request; amo_done=1 with excp_valid=1.
- kill in ST_REQ with req_ready held 0: req_valid drops the next cycle, state=IDLE, amo_done never asserts.
- kill in LD_WAIT with ld_valid 3 cycles later: no store request; busy deasserts the cycle after ld_valid.
- rst driven to 0 in ST_WAIT: busy=0 immediately (asynchronous); a later st_ack is ignored.
